// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB full-speed receive controller.
package usb_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF      = 8'h80;
  localparam int unsigned MAX_DATA_BYTES_DEF = 64;
  localparam int unsigned BIT_TIMEOUT_DEF    = 16;

  // PIDs this receiver accepts; anything else is treated as a protocol error.
  typedef enum logic [3:0] {
    PidOut   = 4'b0001,
    PidIn    = 4'b1001,
    PidSetup = 4'b1101,
    PidData0 = 4'b0011,
    PidData1 = 4'b1011,
    PidAck   = 4'b0010,
    PidNak   = 4'b1010,
    PidStall = 4'b1110
  } pid_t;

  typedef enum logic [1:0] {
    PktToken,
    PktData,
    PktHandshake,
    PktInvalid
  } pkt_class_t;

  // Upper nibble must be the complement of the lower nibble, and the PID must be listed.
  function automatic pkt_class_t pid_classify(logic [7:0] pid_byte);
    pkt_class_t cls;
    cls = PktInvalid;
    if (pid_byte[7:4] == ~pid_byte[3:0]) begin
      case (pid_byte[3:0])
        PidOut, PidIn, PidSetup: cls = PktToken;
        PidData0, PidData1:      cls = PktData;
        PidAck, PidNak, PidStall: cls = PktHandshake;
        default:                 cls = PktInvalid;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/usb_rx_ctrl.sv
// Receive control FSM: sequences SYNC, PID and body bytes of one packet, writes data payload
// to the RX FIFO and reports completion or error.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned MAX_DATA_BYTES = MAX_DATA_BYTES_DEF,
  parameter int unsigned BIT_TIMEOUT    = BIT_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       d_edge_i,
  input  logic       shift_enable_i,
  input  logic       byte_received_i,
  input  logic [7:0] rcv_data_i,
  input  logic       eop_i,
  output logic       rcving_o,
  output logic       w_enable_o,
  output logic       r_error_o,
  output logic [3:0] rx_pid_o,
  output logic       rx_done_o,
  output logic [6:0] byte_count_o
);

  localparam logic [6:0]  MaxCount = 7'(MAX_DATA_BYTES + 2);
  localparam int unsigned ToW      = $clog2(BIT_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSyncWait,
    StPidWait,
    StBody,
    StEopWait,
    StDone,
    StErrWait
  } state_e;

  state_e         state_q;
  logic           is_data_q;
  logic           tok_cnt_q;
  logic [6:0]     byte_count_q;
  logic           rcving_q;
  logic           r_error_q;
  logic [3:0]     rx_pid_q;
  logic           rx_done_q;
  logic [ToW-1:0] to_cnt_q;

  logic       counting;
  logic       timeout;
  logic       room;
  logic       w_enable;
  logic [6:0] count_upd;
  pkt_class_t pid_cls;

  // Decode timeout, FIFO write strobe and the post-write byte count for this cycle.
  always_comb begin
    counting  = (state_q == StSyncWait) || (state_q == StPidWait) || (state_q == StBody);
    timeout   = counting && shift_enable_i && !byte_received_i && (to_cnt_q == ToLast);
    room      = byte_count_q < MaxCount;
    w_enable  = (state_q == StBody) && is_data_q && byte_received_i && room;
    count_upd = byte_count_q + 7'(w_enable);
    pid_cls   = pid_classify(rcv_data_i);
  end

  // Bit-time watchdog: cleared by every byte, counts sampled bits while a byte is expected.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if ((state_q == StIdle) || byte_received_i) begin
      to_cnt_q <= '0;
    end else if (counting && shift_enable_i) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Packet sequencing FSM with registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      is_data_q    <= 1'b0;
      tok_cnt_q    <= 1'b0;
      byte_count_q <= '0;
      rcving_q     <= 1'b0;
      r_error_q    <= 1'b0;
      rx_pid_q     <= 4'h0;
      rx_done_q    <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (d_edge_i) begin
            state_q      <= StSyncWait;
            rcving_q     <= 1'b1;
            r_error_q    <= 1'b0;
            byte_count_q <= '0;
            tok_cnt_q    <= 1'b0;
          end
        end

        StSyncWait: begin
          if (eop_i) begin
            r_error_q <= 1'b1;
            rcving_q  <= 1'b0;
            state_q   <= StIdle;
          end else if (byte_received_i) begin
            if (rcv_data_i == SYNC_BYTE) begin
              state_q <= StPidWait;
            end else begin
              r_error_q <= 1'b1;
              state_q   <= StErrWait;
            end
          end else if (timeout) begin
            r_error_q <= 1'b1;
            state_q   <= StErrWait;
          end
        end

        StPidWait: begin
          if (eop_i) begin
            r_error_q <= 1'b1;
            rcving_q  <= 1'b0;
            state_q   <= StIdle;
          end else if (byte_received_i) begin
            if (pid_cls == PktInvalid) begin
              r_error_q <= 1'b1;
              state_q   <= StErrWait;
            end else begin
              rx_pid_q  <= rcv_data_i[3:0];
              is_data_q <= (pid_cls == PktData);
              state_q   <= (pid_cls == PktHandshake) ? StEopWait : StBody;
            end
          end else if (timeout) begin
            r_error_q <= 1'b1;
            state_q   <= StErrWait;
          end
        end

        StBody: begin
          if (is_data_q) begin
            if (byte_received_i && !room) begin
              // Overlong payload: drop the byte; an eop arriving with it ends the packet now.
              r_error_q <= 1'b1;
              if (eop_i) begin
                rcving_q <= 1'b0;
                state_q  <= StIdle;
              end else begin
                state_q <= StErrWait;
              end
            end else begin
              byte_count_q <= count_upd;
              // A byte coinciding with eop is counted before the length check.
              if (eop_i) begin
                rcving_q <= 1'b0;
                if (count_upd >= 7'd2) begin
                  rx_done_q <= 1'b1;
                  state_q   <= StDone;
                end else begin
                  r_error_q <= 1'b1;
                  state_q   <= StIdle;
                end
              end else if (timeout) begin
                r_error_q <= 1'b1;
                state_q   <= StErrWait;
              end
            end
          end else begin
            // Token body: address/endpoint/CRC5 are two bytes, consumed but not stored.
            if (eop_i) begin
              r_error_q <= 1'b1;
              rcving_q  <= 1'b0;
              state_q   <= StIdle;
            end else if (byte_received_i) begin
              if (tok_cnt_q) begin
                state_q <= StEopWait;
              end else begin
                tok_cnt_q <= 1'b1;
              end
            end else if (timeout) begin
              r_error_q <= 1'b1;
              state_q   <= StErrWait;
            end
          end
        end

        StEopWait: begin
          if (byte_received_i) begin
            r_error_q <= 1'b1;
            if (eop_i) begin
              rcving_q <= 1'b0;
              state_q  <= StIdle;
            end else begin
              state_q <= StErrWait;
            end
          end else if (eop_i) begin
            rcving_q  <= 1'b0;
            rx_done_q <= 1'b1;
            state_q   <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        StErrWait: begin
          if (eop_i) begin
            rcving_q <= 1'b0;
            state_q  <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rcving_o     = rcving_q;
  assign w_enable_o   = w_enable;
  assign r_error_o    = r_error_q;
  assign rx_pid_o     = rx_pid_q;
  assign rx_done_o    = rx_done_q;
  assign byte_count_o = byte_count_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: one task per scenario, inline comparisons.
module tb_usb_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       d_edge;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       eop;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [3:0] rx_pid;
  logic       rx_done;
  logic [6:0] byte_count;

  int checks;
  int errors;
  int wr_n;
  int done_n;
  logic [7:0] wr_log [8];

  usb_rx_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .d_edge_i       (d_edge),
    .shift_enable_i (shift_enable),
    .byte_received_i(byte_received),
    .rcv_data_i     (rcv_data),
    .eop_i          (eop),
    .rcving_o       (rcving),
    .w_enable_o     (w_enable),
    .r_error_o      (r_error),
    .rx_pid_o       (rx_pid),
    .rx_done_o      (rx_done),
    .byte_count_o   (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count FIFO writes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (w_enable) begin
      if (wr_n < 8) wr_log[wr_n] = rcv_data;
      wr_n = wr_n + 1;
    end
    if (rx_done) done_n = done_n + 1;
  end

  // Present one cycle of inputs; returns 1 time unit after the edge that consumed them.
  task automatic cyc(input logic de, input logic se, input logic br, input logic [7:0] d,
                     input logic ep);
    d_edge = de; shift_enable = se; byte_received = br; rcv_data = d; eop = ep;
    @(posedge clk);
    #1;
    d_edge = 1'b0; shift_enable = 1'b0; byte_received = 1'b0; eop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic send_edge();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_eop();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if ({rcving, r_error, rx_done, w_enable, rx_pid, byte_count} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {rcving, r_error, rx_done, w_enable, rx_pid, byte_count});
    end
  endtask

  task automatic test_data_packet();
    logic [7:0] exp [5];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'hAA; exp[4] = 8'hBB;
    wr_n = 0; done_n = 0;
    send_edge();
    checks++;
    if (rcving !== 1'b1) begin errors++; $display("FAIL data_rcving: got %b required 1", rcving); end
    send_byte(8'h80);
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) send_byte(exp[i]);
    send_eop();
    checks++;
    if (rx_done !== 1'b1) begin errors++; $display("FAIL data_done: got %b required 1", rx_done); end
    checks++;
    if (byte_count !== 7'd5) begin
      errors++; $display("FAIL data_count: got %0d required 5", byte_count);
    end
    checks++;
    if (rx_pid !== 4'h3) begin errors++; $display("FAIL data_pid: got %h required 3", rx_pid); end
    checks++;
    if (r_error !== 1'b0 || rcving !== 1'b0) begin
      errors++; $display("FAIL data_flags: got err=%b rcv=%b required 0 0", r_error, rcving);
    end
    idle();
    checks++;
    if (rx_done !== 1'b0 || done_n !== 1) begin
      errors++; $display("FAIL data_done_width: got done=%b pulses=%0d required 0 1", rx_done, done_n);
    end
    checks++;
    if (wr_n !== 5) begin errors++; $display("FAIL data_writes: got %0d required 5", wr_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_log[i] !== exp[i]) begin
        errors++; $display("FAIL data_fifo_byte%0d: got %h required %h", i, wr_log[i], exp[i]);
      end
    end
  endtask

  task automatic test_handshake();
    wr_n = 0; done_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'hD2); send_eop();
    checks++;
    if (rx_done !== 1'b1 || rx_pid !== 4'h2) begin
      errors++; $display("FAIL ack_done_pid: got done=%b pid=%h required 1 2", rx_done, rx_pid);
    end
    idle();
    checks++;
    if (wr_n !== 0) begin errors++; $display("FAIL ack_no_write: got %0d required 0", wr_n); end
    // Handshake followed by an extra byte is too long.
    done_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'hD2); send_byte(8'h00);
    checks++;
    if (r_error !== 1'b1) begin errors++; $display("FAIL ack_long_err: got %b required 1", r_error); end
    send_eop(); idle();
    checks++;
    if (done_n !== 0 || rcving !== 1'b0) begin
      errors++; $display("FAIL ack_long_done: got pulses=%0d rcv=%b required 0 0", done_n, rcving);
    end
    send_edge();
    checks++;
    if (r_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", r_error); end
    send_eop(); // eop while waiting for SYNC aborts straight to idle
    checks++;
    if (r_error !== 1'b1 || rcving !== 1'b0) begin
      errors++; $display("FAIL sync_eop: got err=%b rcv=%b required 1 0", r_error, rcving);
    end
  endtask

  task automatic test_bad_sync_pid();
    send_edge(); send_byte(8'h81);
    checks++;
    if (r_error !== 1'b1 || rcving !== 1'b1) begin
      errors++; $display("FAIL badsync: got err=%b rcv=%b required 1 1", r_error, rcving);
    end
    idle(); idle();
    checks++;
    if (rcving !== 1'b1) begin errors++; $display("FAIL badsync_hold: got %b required 1", rcving); end
    send_eop();
    checks++;
    if (rcving !== 1'b0 || r_error !== 1'b1) begin
      errors++; $display("FAIL badsync_eop: got rcv=%b err=%b required 0 1", rcving, r_error);
    end
    send_edge(); send_byte(8'h80); send_byte(8'h33);
    checks++;
    if (r_error !== 1'b1 || rx_pid !== 4'h2) begin
      errors++; $display("FAIL badpid: got err=%b pid=%h required 1 2", r_error, rx_pid);
    end
    send_eop();
  endtask

  task automatic test_max_length();
    wr_n = 0; done_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'h4B);
    for (int i = 0; i < 66; i++) send_byte(8'(i));
    send_eop();
    checks++;
    if (rx_done !== 1'b1 || byte_count !== 7'd66 || rx_pid !== 4'hB) begin
      errors++;
      $display("FAIL max66: got done=%b cnt=%0d pid=%h required 1 66 b", rx_done, byte_count, rx_pid);
    end
    idle();
    checks++;
    if (wr_n !== 66) begin errors++; $display("FAIL max66_writes: got %0d required 66", wr_n); end
    wr_n = 0; done_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'h4B);
    for (int i = 0; i < 67; i++) send_byte(8'(i));
    checks++;
    if (r_error !== 1'b1 || wr_n !== 66 || byte_count !== 7'd66) begin
      errors++;
      $display("FAIL over67: got err=%b writes=%0d cnt=%0d required 1 66 66", r_error, wr_n, byte_count);
    end
    send_eop(); idle();
    checks++;
    if (done_n !== 0) begin errors++; $display("FAIL over67_done: got %0d required 0", done_n); end
  endtask

  task automatic test_timeout();
    wr_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'hC3); send_byte(8'h01);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (r_error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b required 0", r_error); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (r_error !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b required 1", r_error); end
    send_byte(8'h02);
    checks++;
    if (wr_n !== 1) begin errors++; $display("FAIL timeout_suppress: got %0d required 1", wr_n); end
    send_eop();
  endtask

  task automatic test_back_to_back();
    done_n = 0; wr_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rst = 1'b1;
    #1;
    checks++;
    if ({rcving, r_error, rx_done, rx_pid, byte_count} !== 14'h0) begin
      errors++;
      $display("FAIL midreset: got %h required 0", {rcving, r_error, rx_done, rx_pid, byte_count});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    send_edge(); send_byte(8'h80); send_byte(8'hD2); send_eop();
    checks++;
    if (rx_done !== 1'b1 || r_error !== 1'b0 || done_n !== 0) begin
      errors++;
      $display("FAIL post_reset_ack: got done=%b err=%b prior=%0d required 1 0 0", rx_done, r_error, done_n);
    end
    idle();
    // Token packet: two body bytes are consumed, nothing reaches the FIFO.
    wr_n = 0;
    send_edge(); send_byte(8'h80); send_byte(8'hE1); send_byte(8'h12); send_byte(8'h34);
    send_eop();
    checks++;
    if (rx_done !== 1'b1 || rx_pid !== 4'h1 || byte_count !== 7'd0) begin
      errors++;
      $display("FAIL token: got done=%b pid=%h cnt=%0d required 1 1 0", rx_done, rx_pid, byte_count);
    end
    idle();
    // Byte and eop together at count 1 complete a valid 2-byte packet.
    send_edge(); send_byte(8'h80); send_byte(8'hC3); send_byte(8'h5A);
    cyc(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
    checks++;
    if (rx_done !== 1'b1 || byte_count !== 7'd2 || r_error !== 1'b0) begin
      errors++;
      $display("FAIL byte_eop: got done=%b cnt=%0d err=%b required 1 2 0", rx_done, byte_count, r_error);
    end
    idle();
    checks++;
    if (wr_n !== 2) begin errors++; $display("FAIL byte_eop_writes: got %0d required 2", wr_n); end
  endtask

  initial begin
    checks = 0; errors = 0; wr_n = 0; done_n = 0;
    rst = 1'b1; d_edge = 1'b0; shift_enable = 1'b0; byte_received = 1'b0;
    rcv_data = 8'h00; eop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    idle();
    test_data_packet();
    test_handshake();
    test_bad_sync_pid();
    test_max_length();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
